fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly downstream of the PC register.
- Takes the current PC value and issues a request/acknowledge read to instruction memory.
- Writes the returned instruction into the IF/ID pipeline register.
- Generates the PC write-enable that advances the PC, or loads a branch target on flush.
- Absorbs variable memory latency, ID-stage stalls, and branch flushes that arrive while a fetch is in flight.

Parameters:
ADDR_W, 32, PC / instruction address width
INST_W, 32, instruction width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-low reset
start_i  in  1  core run enable; no new fetch is issued while low
pc_i  in  ADDR_W  current PC value (PC register output)
pc_write_o  out  1  PC write-enable (Mealy, combinational); PC loads its next-PC mux at the edge
stall_i  in  1  ID hazard stall; IF/ID must hold
flush_i  in  1  branch/jump taken; discard fetched or in-flight instruction
imem_req_o  out  1  memory request, registered
imem_addr_o  out  ADDR_W  request address, registered, stable while imem_req_o=1
imem_ack_i  in  1  one-cycle data-valid strobe from instruction memory
imem_data_i  in  INST_W  instruction data, valid with imem_ack_i
if_valid_o  out  1  IF/ID holds a real instruction
if_pc_o  out  ADDR_W  PC of the IF/ID instruction
if_pc4_o  out  ADDR_W  if_pc_o+4, modulo 2^ADDR_W
if_inst_o  out  INST_W  IF/ID instruction

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State=IDLE.
  - imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_pc4_o, if_inst_o, hold buffer all 0.
  - pc_write_o=0.
  - Reset mid-fetch abandons the request; any later imem_ack_i while in IDLE is ignored.
- States: IDLE (no request), WAIT (request outstanding), HOLD (instruction buffered, IF/ID stalled), DROP (flushed request awaiting ack).
- IDLE:
  - If start_i=1 and flush_i=0: next edge imem_req_o<=1, imem_addr_o<=pc_i, ->WAIT.
  - If flush_i=1: pc_write_o=1, no issue, stay IDLE.
- WAIT:
  - imem_req_o held at 1; imem_addr_o unchanged.
  - flush_i=1: pc_write_o=1, if_valid_o<=0.
    - With imem_ack_i=1: data discarded, imem_req_o<=0, ->IDLE.
    - Without imem_ack_i: ->DROP.
  - imem_ack_i=1, flush_i=0, stall_i=0:
    - if_inst_o<=imem_data_i, if_pc_o<=imem_addr_o, if_pc4_o<=imem_addr_o+4, if_valid_o<=1.
    - pc_write_o=1, imem_req_o<=0, ->IDLE.
  - imem_ack_i=1, stall_i=1, flush_i=0: data and address into hold buffer, imem_req_o<=0, pc_write_o=0, ->HOLD.
- HOLD:
  - flush_i=1: buffer discarded, pc_write_o=1, if_valid_o<=0, ->IDLE.
  - stall_i=0: buffer moved to IF/ID (if_valid_o<=1), pc_write_o=1, ->IDLE.
  - Otherwise: hold.
- DROP:
  - imem_req_o held at 1.
  - On imem_ack_i: data discarded, imem_req_o<=0, ->IDLE.
  - flush_i during DROP: pc_write_o=1, still DROP.
- IF/ID bubbles: in any cycle where no instruction is written, stall_i=0 and flush_i=0, if_valid_o<=0; other IF/ID fields hold.
- Priority: flush_i over stall_i over ack delivery. stall_i=1 without flush_i holds all IF/ID outputs.
- pc_write_o=1 only in the cycles listed above. The PC is never written while a non-flushed request is outstanding.
- Latency and throughput: 0-wait-state memory (ack in the first WAIT cycle) gives 2 cycles per instruction; each memory wait state adds 1.
- start_i dropping mid-fetch: the outstanding request completes normally; no new issue.
- if_pc4_o wraps at 2^ADDR_W (0xFFFFFFFC -> 0x00000000).

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_fetch_o[31:0] and perf_stall_o[31:0].
  - perf_fetch_o counts instructions written into IF/ID with if_valid_o<=1.
  - perf_stall_o counts cycles spent in WAIT, HOLD or DROP.
  - Both reset to 0 and wrap at 2^32.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset release, start_i=1, pc_i=0x0, memory acks 1 cycle after req -> imem_addr_o=0x0; on ack, pc_write_o=1, if_inst_o=data, if_pc_o=0x0, if_pc4_o=0x4, if_valid_o=1.
- Memory with 3 wait states, pc_i=0x40 -> imem_addr_o stable at 0x40 for 4 cycles; pc_write_o stays 0 until ack; one instruction per 5 cycles.
- stall_i=1 held 4 cycles across ack of 0x8 -> HOLD; IF/ID unchanged; on stall_i=0, if_pc_o=0x8 and pc_write_o=1 in the same cycle.
- flush_i pulsed 1 cycle after req for 0x10, ack 2 cycles later -> pc_write_o=1 in flush cycle; if_valid_o=0; ack data never appears; next request uses the new pc_i (e.g. 0x100).
- flush_i and stall_i both 1 in HOLD -> buffer discarded, if_valid_o=0, pc_write_o=1.
- rst_i asserted while in WAIT -> all outputs 0 immediately; a late imem_ack_i is ignored; pc_i=0xFFFFFFFC fetch yields if_pc4_o=0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Issues req/ack reads to instruction
//               memory at the current PC and loads the IF/ID pipeline register.
//               It absorbs memory wait states, ID stalls and branch flushes.
//               Optional build macro FETCH_PERF_CNT_EN adds fetch/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pc_write_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_data_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [ADDR_W-1:0] if_pc4_o,
  output logic [INST_W-1:0] if_inst_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_o,
  output logic [31:0]       perf_stall_o
`endif
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_wait = 2'd1;
  localparam logic [1:0] c_hold = 2'd2;
  localparam logic [1:0] c_drop = 2'd3;

  localparam logic [ADDR_W-1:0] c_inst_bytes = ADDR_W'(4);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;

  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic              r_valid;
  logic [ADDR_W-1:0] r_if_pc;
  logic [ADDR_W-1:0] r_if_pc4;
  logic [INST_W-1:0] r_if_inst;
  logic [ADDR_W-1:0] r_hold_pc;
  logic [INST_W-1:0] r_hold_inst;

  logic              w_pc_write;
  logic              w_issue;
  logic              w_req_clr;
  logic              w_load_ack;
  logic              w_load_hold;
  logic              w_buf_ack;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: flush beats stall, stall beats ack delivery
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle: begin
        if (!flush_i && start_i) begin
          w_state_nxt = c_wait;
        end
      end
      c_wait: begin
        if (flush_i) begin
          w_state_nxt = imem_ack_i ? c_idle : c_drop;
        end else if (imem_ack_i) begin
          w_state_nxt = stall_i ? c_hold : c_idle;
        end
      end
      c_hold: begin
        if (flush_i || !stall_i) begin
          w_state_nxt = c_idle;
        end
      end
      c_drop: begin
        if (imem_ack_i) begin
          w_state_nxt = c_idle;
        end
      end
      default: w_state_nxt = c_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_pc_write  = 1'b0;
    w_issue     = 1'b0;
    w_req_clr   = 1'b0;
    w_load_ack  = 1'b0;
    w_load_hold = 1'b0;
    w_buf_ack   = 1'b0;
    case (r_state)
      c_idle: begin
        if (flush_i) begin
          w_pc_write = 1'b1;
        end else if (start_i) begin
          w_issue = 1'b1;
        end
      end
      c_wait: begin
        if (flush_i) begin
          w_pc_write = 1'b1;
          w_req_clr  = imem_ack_i;
        end else if (imem_ack_i) begin
          w_req_clr = 1'b1;
          if (stall_i) begin
            w_buf_ack = 1'b1;
          end else begin
            w_load_ack = 1'b1;
            w_pc_write = 1'b1;
          end
        end
      end
      c_hold: begin
        if (flush_i) begin
          w_pc_write = 1'b1;
        end else if (!stall_i) begin
          w_load_hold = 1'b1;
          w_pc_write  = 1'b1;
        end
      end
      c_drop: begin
        w_pc_write = flush_i;
        w_req_clr  = imem_ack_i;
      end
      default: begin
        w_pc_write = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Memory request port; address is frozen for the whole request
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_req  <= 1'b0;
      r_addr <= '0;
    end else if (w_issue) begin
      r_req  <= 1'b1;
      r_addr <= pc_i;
    end else if (w_req_clr) begin
      r_req  <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Hold buffer: catches an ack that lands while ID is stalled
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_hold_pc   <= '0;
      r_hold_inst <= '0;
    end else if (w_buf_ack) begin
      r_hold_pc   <= r_addr;
      r_hold_inst <= imem_data_i;
    end
  end

  // --------------------------------------------------------------------------
  // IF/ID pipeline register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid   <= 1'b0;
      r_if_pc   <= '0;
      r_if_pc4  <= '0;
      r_if_inst <= '0;
    end else if (flush_i) begin
      r_valid   <= 1'b0;
    end else if (w_load_ack) begin
      r_valid   <= 1'b1;
      r_if_pc   <= r_addr;
      r_if_pc4  <= r_addr + c_inst_bytes;
      r_if_inst <= imem_data_i;
    end else if (w_load_hold) begin
      r_valid   <= 1'b1;
      r_if_pc   <= r_hold_pc;
      r_if_pc4  <= r_hold_pc + c_inst_bytes;
      r_if_inst <= r_hold_inst;
    end else if (!stall_i) begin
      r_valid   <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_load_ack || w_load_hold) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if (r_state != c_idle) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetch_o = r_perf_fetch;
  assign perf_stall_o = r_perf_stall;
`endif

  assign pc_write_o  = w_pc_write;
  assign imem_req_o  = r_req;
  assign imem_addr_o = r_addr;
  assign if_valid_o  = r_valid;
  assign if_pc_o     = r_if_pc;
  assign if_pc4_o    = r_if_pc4;
  assign if_inst_o   = r_if_inst;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [ADDR_W-1:0] pc_i;
  logic              pc_write_o;
  logic              stall_i;
  logic              flush_i;
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_ack_i;
  logic [INST_W-1:0] imem_data_i;
  logic              if_valid_o;
  logic [ADDR_W-1:0] if_pc_o;
  logic [ADDR_W-1:0] if_pc4_o;
  logic [INST_W-1:0] if_inst_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]       perf_fetch_o;
  logic [31:0]       perf_stall_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  fetch_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .pc_i        (pc_i),
    .pc_write_o  (pc_write_o),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .imem_req_o  (imem_req_o),
    .imem_addr_o (imem_addr_o),
    .imem_ack_i  (imem_ack_i),
    .imem_data_i (imem_data_i),
    .if_valid_o  (if_valid_o),
    .if_pc_o     (if_pc_o),
    .if_pc4_o    (if_pc4_o),
    .if_inst_o   (if_inst_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_o(perf_fetch_o),
    .perf_stall_o(perf_stall_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Inputs change 1ns after an edge; the extra 1ns lets pc_write_o settle
  task automatic drive(input logic st, input logic [ADDR_W-1:0] pc, input logic ack,
                       input logic [INST_W-1:0] d, input logic stl, input logic fl);
    start_i     = st;
    pc_i        = pc;
    imem_ack_i  = ack;
    imem_data_i = d;
    stall_i     = stl;
    flush_i     = fl;
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [ADDR_W-1:0] pc,
                            input logic [INST_W-1:0] inst);
    check({tag, ".valid"}, 64'(if_valid_o), 64'(v));
    check({tag, ".pc"},    64'(if_pc_o),    64'(pc));
    check({tag, ".pc4"},   64'(if_pc4_o),   64'(pc + 32'd4));
    check({tag, ".inst"},  64'(if_inst_o),  64'(inst));
  endtask

  task automatic check_req(input string tag, input logic req, input logic [ADDR_W-1:0] addr);
    check({tag, ".req"},  64'(imem_req_o),  64'(req));
    check({tag, ".addr"}, 64'(imem_addr_o), 64'(addr));
  endtask

  initial begin
    rst_i = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    // Reset state
    check("rst.pcw", 64'(pc_write_o), 64'd0);
    check_req("rst", 1'b0, 32'h0);
    check("rst.valid", 64'(if_valid_o), 64'd0);
    check("rst.pc", 64'(if_pc_o), 64'd0);
    check("rst.pc4", 64'(if_pc4_o), 64'd0);
    check("rst.inst", 64'(if_inst_o), 64'd0);
    tick();
    rst_i = 1'b1;

    // Zero-wait fetch at 0x0
    drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("f0.issue.pcw", 64'(pc_write_o), 64'd0);
    tick();
    check_req("f0.wait", 1'b1, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    check("f0.ack.pcw", 64'(pc_write_o), 64'd1);
    tick();
    check_req("f0.done", 1'b0, 32'h0);
    check_ifid("f0", 1'b1, 32'h0, 32'hDEADBEEF);

    // Three wait states at 0x40
    drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check_req("ws.issue", 1'b1, 32'h40);
    check("ws.bubble", 64'(if_valid_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
      check($sformatf("ws.w%0d.pcw", i), 64'(pc_write_o), 64'd0);
      tick();
      check_req($sformatf("ws.w%0d", i), 1'b1, 32'h40);
    end
    drive(1'b0, 32'h40, 1'b1, 32'h11111111, 1'b0, 1'b0);
    check("ws.ack.pcw", 64'(pc_write_o), 64'd1);
    tick();
    check_ifid("ws", 1'b1, 32'h40, 32'h11111111);

    // Stall across the ack of 0x8
    drive(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check_req("st.issue", 1'b1, 32'h8);
    drive(1'b0, 32'h8, 1'b1, 32'h22222222, 1'b1, 1'b0);
    check("st.ack.pcw", 64'(pc_write_o), 64'd0);
    tick();
    check_req("st.hold", 1'b0, 32'h8);
    check_ifid("st.h0", 1'b0, 32'h40, 32'h11111111);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h8, 1'b0, 32'h0, 1'b1, 1'b0);
      check($sformatf("st.h%0d.pcw", i + 1), 64'(pc_write_o), 64'd0);
      tick();
      check_ifid($sformatf("st.h%0d", i + 1), 1'b0, 32'h40, 32'h11111111);
    end
    drive(1'b0, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0);
    check("st.rel.pcw", 64'(pc_write_o), 64'd1);
    tick();
    check_ifid("st.rel", 1'b1, 32'h8, 32'h22222222);

    // Flush while fetching 0x10, late ack dropped, refetch at 0x100
    drive(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check_req("fl.issue", 1'b1, 32'h10);
    drive(1'b0, 32'h10, 1'b0, 32'h0, 1'b0, 1'b1);
    check("fl.flush.pcw", 64'(pc_write_o), 64'd1);
    tick();
    check_req("fl.drop", 1'b1, 32'h10);
    check("fl.drop.valid", 64'(if_valid_o), 64'd0);
    drive(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    check("fl.drop.pcw", 64'(pc_write_o), 64'd0);
    tick();
    drive(1'b0, 32'h100, 1'b1, 32'h33333333, 1'b0, 1'b0);
    check("fl.lateack.pcw", 64'(pc_write_o), 64'd0);
    tick();
    check_req("fl.lateack", 1'b0, 32'h10);
    check_ifid("fl.lateack", 1'b0, 32'h8, 32'h22222222);
    drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check_req("fl.refetch", 1'b1, 32'h100);
    drive(1'b0, 32'h100, 1'b1, 32'h44444444, 1'b0, 1'b0);
    tick();
    check_ifid("fl.refetch", 1'b1, 32'h100, 32'h44444444);

    // Flush in IDLE only writes the PC
    drive(1'b1, 32'h180, 1'b0, 32'h0, 1'b0, 1'b1);
    check("idfl.pcw", 64'(pc_write_o), 64'd1);
    tick();
    check_req("idfl", 1'b0, 32'h100);
    check("idfl.valid", 64'(if_valid_o), 64'd0);

    // Flush and stall together in HOLD
    drive(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h200, 1'b1, 32'h55555555, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h200, 1'b0, 32'h0, 1'b1, 1'b1);
    check("hfl.pcw", 64'(pc_write_o), 64'd1);
    tick();
    check_ifid("hfl", 1'b0, 32'h100, 32'h44444444);
    drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0);
    check("hfl.idle.pcw", 64'(pc_write_o), 64'd0);
    tick();
    check_req("hfl.next", 1'b1, 32'h300);
    drive(1'b0, 32'h300, 1'b1, 32'h66666666, 1'b0, 1'b0);
    tick();
    check_ifid("hfl.next", 1'b1, 32'h300, 32'h66666666);

    // Reset during WAIT, late ack ignored
    drive(1'b1, 32'h400, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check_req("rw.issue", 1'b1, 32'h400);
    drive(1'b0, 32'h400, 1'b0, 32'h0, 1'b0, 1'b0);
    rst_i = 1'b0;
    #1;
    check_req("rw.rst", 1'b0, 32'h0);
    check("rw.rst.valid", 64'(if_valid_o), 64'd0);
    check("rw.rst.pc", 64'(if_pc_o), 64'd0);
    check("rw.rst.inst", 64'(if_inst_o), 64'd0);
    tick();
    rst_i = 1'b1;
    drive(1'b0, 32'h400, 1'b1, 32'h77777777, 1'b0, 1'b0);
    check("rw.late.pcw", 64'(pc_write_o), 64'd0);
    tick();
    check_req("rw.late", 1'b0, 32'h0);
    check("rw.late.valid", 64'(if_valid_o), 64'd0);
    check("rw.late.inst", 64'(if_inst_o), 64'd0);

    // PC+4 wraps at the top of the address space
    drive(1'b1, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check_req("wrap.issue", 1'b1, 32'hFFFFFFFC);
    drive(1'b0, 32'hFFFFFFFC, 1'b1, 32'h88888888, 1'b0, 1'b0);
    tick();
    check("wrap.valid", 64'(if_valid_o), 64'd1);
    check("wrap.pc", 64'(if_pc_o), 64'hFFFFFFFC);
    check("wrap.pc4", 64'(if_pc4_o), 64'h0);
    check("wrap.inst", 64'(if_inst_o), 64'h88888888);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
